// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM: sequences PC write/select and fetch-latch load/flush
// across branch redirects, load-use stalls and imem wait states. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_sequencer #(
  parameter int                  ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC     = 32'h0000_0000,
  parameter int                  FLUSH_CYCLES = 1,
  parameter int                  CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              hazard_stall,
  input  logic              imem_ack,
  output logic              imem_req,
  output logic              pc_we,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              latch_en,
  output logic              latch_flush,
`ifdef FETCH_PERF_CNT_EN
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_cycles,
`endif
  output logic              fetch_valid
);

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10,
    FLUSH = 2'b11
  } state_t;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] flush_cnt_r;
  logic       redirect_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and Mealy outputs; a taken branch outranks everything outside BOOT
  always_comb begin
    state_nxt_s = state_r;
    imem_req    = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    latch_en    = 1'b0;
    latch_flush = 1'b0;
    redirect_s  = 1'b0;
    if (state_r == BOOT) begin
      pc_we       = 1'b1;
      pc_sel      = 1'b1;
      latch_flush = 1'b1;
      state_nxt_s = RUN;
    end else if (br_taken) begin
      latch_en    = 1'b1;
      latch_flush = 1'b1;
      redirect_s  = 1'b1;
      state_nxt_s = FLUSH;
    end else begin
      case (state_r)
        RUN: begin
          if (hazard_stall) begin
            state_nxt_s = STALL;
          end else if (!imem_ack) begin
            imem_req = 1'b1;
          end else begin
            imem_req = 1'b1;
            pc_we    = 1'b1;
            latch_en = 1'b1;
          end
        end
        STALL: begin
          if (hazard_stall) begin
            state_nxt_s = STALL;
          end else begin
            state_nxt_s = RUN;
          end
        end
        FLUSH: begin
          latch_en    = 1'b1;
          latch_flush = 1'b1;
          if (flush_cnt_r == FLUSH_LAST) begin
            pc_we  = 1'b1;
            pc_sel = 1'b1;
          end else begin
            pc_we  = 1'b0;
            pc_sel = 1'b0;
          end
          if (flush_cnt_r == 4'd0) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = FLUSH;
          end
        end
        default: begin
          state_nxt_s = BOOT;
        end
      endcase
    end
  end

  // Redirect address and flush bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_pc <= RESET_PC;
      flush_cnt_r <= 4'd0;
    end else if (redirect_s) begin
      redirect_pc <= br_target;
      flush_cnt_r <= FLUSH_LAST;
    end else if ((state_r == FLUSH) && (flush_cnt_r != 4'd0)) begin
      flush_cnt_r <= flush_cnt_r - 4'd1;
    end
  end

  // Fetch-latch validity; a flush always wins over a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
    end else if (latch_flush) begin
      fetch_valid <= 1'b0;
    end else if (latch_en) begin
      fetch_valid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall_evt_s;
  logic flush_evt_s;

  assign stall_evt_s = (state_r == STALL) || ((state_r == RUN) && !imem_ack);
  assign flush_evt_s = (state_r == FLUSH);

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (stall_evt_s && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (flush_evt_s && (flush_cycles != {CNT_W{1'b1}})) begin
        flush_cycles <= flush_cycles + CNT_W'(1);
      end
    end
  end
`endif

endmodule
